// File: rtl/muldiv.sv
// muldiv: iterative multiply/divide unit holding the HI/LO result registers.
// It produces one product or quotient bit per clock: shift-add for multiply
// and restoring shift-subtract for divide. Signed operations run on operand
// magnitudes, and the sign is fixed up when the result is loaded.
module muldiv #(
    parameter int WIDTH = 32,
    parameter int CNTW  = 5
) (
    input  logic             clk,
    input  logic             clrn,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             start,
    input  logic [1:0]       op,
    input  logic             whi,
    input  logic             wlo,
    output logic             busy,
    output logic             ready,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);

    typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

    state_t           r_state;
    logic [CNTW-1:0]  r_cnt;
    logic             r_div;      // 1: divide, 0: multiply
    logic [WIDTH-1:0] r_m;        // multiplicand / divisor magnitude
    logic [WIDTH-1:0] r_acc;      // product high half / partial remainder
    logic [WIDTH-1:0] r_q;        // multiplier bits out, quotient bits in
    logic             r_neg;      // result (product / quotient) is negative
    logic             r_dneg;     // dividend negative: remainder takes its sign
    logic             r_dz;       // divide by zero
    logic [WIDTH-1:0] r_araw;     // raw dividend, returned as HI on divide by zero

    // Operand sign and magnitude at the start edge. op[0]=1 marks unsigned.
    logic             w_a_neg, w_b_neg;
    logic [WIDTH-1:0] w_a_mag, w_b_mag;

    assign w_a_neg = ~op[0] & a[WIDTH-1];
    assign w_b_neg = ~op[0] & b[WIDTH-1];
    assign w_a_mag = w_a_neg ? -a : a;
    assign w_b_mag = w_b_neg ? -b : b;

    // One iteration step: next accumulator and shift register values.
    logic [WIDTH:0]   w_sum, w_shift, w_diff;
    logic [WIDTH-1:0] w_acc_n, w_q_n;

    always_comb begin
        w_sum   = {1'b0, r_acc} + (r_q[0] ? {1'b0, r_m} : '0);
        w_shift = {r_acc, r_q[WIDTH-1]};
        w_diff  = w_shift - {1'b0, r_m};
        if (r_div) begin
            if (!w_diff[WIDTH]) begin
                w_acc_n = w_diff[WIDTH-1:0];
                w_q_n   = {r_q[WIDTH-2:0], 1'b1};
            end else begin
                w_acc_n = w_shift[WIDTH-1:0];
                w_q_n   = {r_q[WIDTH-2:0], 1'b0};
            end
        end else begin
            w_acc_n = w_sum[WIDTH:1];
            w_q_n   = {w_sum[0], r_q[WIDTH-1:1]};
        end
    end

    // Sign-corrected final result, taken from the last iteration's outputs.
    logic [2*WIDTH-1:0] w_prod;
    logic [WIDTH-1:0]   w_hi_res, w_lo_res;

    always_comb begin
        w_prod = {w_acc_n, w_q_n};
        if (r_neg) w_prod = -w_prod;
        if (!r_div) begin
            w_hi_res = w_prod[2*WIDTH-1:WIDTH];
            w_lo_res = w_prod[WIDTH-1:0];
        end else if (r_dz) begin
            w_hi_res = r_araw;
            w_lo_res = '1;
        end else begin
            w_hi_res = r_dneg ? -w_acc_n : w_acc_n;
            w_lo_res = r_neg  ? -w_q_n   : w_q_n;
        end
    end

    // Control FSM, iteration datapath and the HI/LO registers.
    always_ff @(posedge clk or negedge clrn) begin
        if (!clrn) begin
            r_state <= S_IDLE;
            r_cnt   <= '0;
            r_div   <= 1'b0;
            r_m     <= '0;
            r_acc   <= '0;
            r_q     <= '0;
            r_neg   <= 1'b0;
            r_dneg  <= 1'b0;
            r_dz    <= 1'b0;
            r_araw  <= '0;
            busy    <= 1'b0;
            ready   <= 1'b0;
            hi      <= '0;
            lo      <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    ready <= 1'b0;
                    if (start) begin
                        r_div   <= op[1];
                        r_m     <= w_b_mag;
                        r_q     <= w_a_mag;
                        r_acc   <= '0;
                        r_cnt   <= '0;
                        r_neg   <= w_a_neg ^ w_b_neg;
                        r_dneg  <= w_a_neg;
                        r_dz    <= op[1] & (b == '0);
                        r_araw  <= a;
                        busy    <= 1'b1;
                        r_state <= S_RUN;
                    end else begin
                        if (whi) hi <= a;
                        if (wlo) lo <= a;
                    end
                end
                S_RUN: begin
                    r_acc <= w_acc_n;
                    r_q   <= w_q_n;
                    r_cnt <= r_cnt + 1'b1;
                    if (r_cnt == {CNTW{1'b1}}) begin
                        hi      <= w_hi_res;
                        lo      <= w_lo_res;
                        busy    <= 1'b0;
                        ready   <= 1'b1;
                        r_state <= S_DONE;
                    end
                end
                S_DONE: begin
                    ready   <= 1'b0;
                    r_state <= S_IDLE;
                end
                default: begin
                    busy    <= 1'b0;
                    ready   <= 1'b0;
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: doc/muldiv.md
Name: muldiv

Overview:
Iterative multiply/divide unit. It sits directly downstream of the register file read ports: it consumes the qa/qb operand pair and holds the HI/LO result registers. Later mfhi/mflo selection feeds hi/lo back into the register file write-data path. The execution is multi-cycle (one bit per clock), and a busy/ready handshake with the control unit stalls the pipeline during execution.

Parameters:
WIDTH, 32, operand width; hi and lo are each WIDTH bits.
CNTW, 5, iteration counter width; must satisfy 2**CNTW == WIDTH.

Ports:
clk  input  1  clock, rising-edge active
clrn  input  1  asynchronous reset, active-low
a  input  WIDTH  operand A (rs data / qa); also the write data for mthi/mtlo
b  input  WIDTH  operand B (rt data / qb)
start  input  1  begin operation; sampled only in IDLE
op  input  2  00 mult (signed), 01 multu, 10 div (signed), 11 divu
whi  input  1  mthi: hi <= a; honoured only in IDLE and only when start=0
wlo  input  1  mtlo: lo <= a; honoured only in IDLE and only when start=0
busy  output  1  high while iterating
ready  output  1  one-cycle pulse when hi/lo hold a new result
hi  output  WIDTH  HI register (product high word / remainder)
lo  output  WIDTH  LO register (product low word / quotient)

Behaviour:
- Reset (clrn=0, asynchronous, any state): state=IDLE, hi=0, lo=0, busy=0, ready=0, counter=0. An operation in flight is abandoned; no partial result reaches hi/lo.
- States: IDLE, RUN, DONE.
- IDLE: on an edge with start=1:
  - Latch op and operand magnitudes. For signed ops use absolute values; record the result sign and the dividend sign.
  - Clear the accumulator and set counter=0; go to RUN.
  - whi/wlo are ignored on that same edge (start has priority).
  - whi and wlo asserted together write both registers.
- RUN: busy=1. Each edge performs one iteration and increments the counter.
  - Multiply: shift-add, one multiplier bit per cycle.
  - Divide: restoring shift-subtract, one quotient bit per cycle.
  - On the edge completing iteration WIDTH (counter wraps from 31 to 0), apply sign correction, load hi/lo, and go to DONE.
  - start, whi and wlo are ignored in RUN.
- DONE: ready=1, busy=0, hi/lo valid. Go to IDLE unconditionally on the next edge. start is ignored in DONE.
- Latency: start sampled at edge E0; busy high for the 32 cycles E0..E32; ready high for the cycle after E32. Back-to-back operations therefore have a start-to-start interval of 34 cycles.
- Multiply: {hi,lo} = full 2*WIDTH product. For signed ops, the 64-bit magnitude is two's-complement negated when the operand signs differ.
- Divide, signed:
  - lo = quotient truncated toward zero; hi = remainder, carrying the sign of the dividend.
  - 0x80000000 / 0xFFFFFFFF gives lo=0x80000000, hi=0 (no trap).
- Divide by zero (b=0, div or divu): lo=0xFFFFFFFF, hi=a as originally presented (unmodified raw value). This holds regardless of sign.
- hi/lo change only on:
  - the RUN->DONE edge;
  - a whi/wlo write in IDLE;
  - reset.
- Operands a/b may change freely after the start edge; they are latched internally.

Test Plan:
- multu a=0xFFFFFFFF b=0xFFFFFFFF, start at edge n -> busy for 32 cycles, ready high in cycle n+33 only; hi=0xFFFFFFFE lo=0x00000001.
- mult a=0xFFFFFFFD (-3) b=7 -> hi=0xFFFFFFFF lo=0xFFFFFFEB. Then mult a=0xFFFFFFFF b=0xFFFFFFFF -> hi=0 lo=1.
- div a=0xFFFFFFF9 (-7) b=2 -> lo=0xFFFFFFFD hi=0xFFFFFFFF. Then div a=0x80000000 b=0xFFFFFFFF -> lo=0x80000000 hi=0.
- divu a=7 b=0 -> lo=0xFFFFFFFF hi=7. Then divu a=100 b=7 -> lo=14 hi=2.
- Writes and starts ignored when not allowed:
  - whi=1 a=0x1234 in IDLE -> hi=0x1234 next edge, lo unchanged.
  - whi/wlo/start pulsed mid-RUN -> ignored; the final result is that of the original operation.
- clrn low at iteration 10 of a divu -> hi=lo=0 and busy=ready=0 immediately. After release, a fresh multu 3*5 -> lo=15 hi=0 with full 33-cycle latency.
